// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// FSM states, ALU control codes and datapath mux selects.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_MODE_ADD   = 2'd0,
        ALU_MODE_SUB   = 2'd1,
        ALU_MODE_FUNCT = 2'd2,
        ALU_MODE_IMM   = 2'd3
    } alu_mode_t;

    // State entered after DECODE; unknown opcodes trap or fall back to FETCH.
    function automatic state_t decode_target(input logic [5:0] op, input logic trap_en);
        state_t s;
        case (op)
            OP_RTYPE:                            s = S_R_EXEC;
            OP_LW, OP_SW:                        s = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                      s = S_BRANCH;
            OP_J:                                s = S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   s = S_I_EXEC;
            default:                             s = trap_en ? S_TRAP : S_FETCH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control: fixed add/sub, or derived from funct (R-type)
// or from opcode (immediate arithmetic/logic).
module mips_alu_decoder
    import mips_pkg::*;
(
    input  alu_mode_t   mode,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [3:0]  alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (mode)
            ALU_MODE_ADD: alu_ctrl = ALU_ADD;
            ALU_MODE_SUB: alu_ctrl = ALU_SUB;
            ALU_MODE_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_NOR:  alu_ctrl = ALU_NOR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            ALU_MODE_IMM: begin
                case (opcode)
                    OP_ANDI: alu_ctrl = ALU_AND;
                    OP_ORI:  alu_ctrl = ALU_OR;
                    OP_SLTI: alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and write enable, stalling on mem_ready.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  pc_source,
    output logic        illegal,
    output logic [31:0] instr_count,
    output logic [3:0]  state_dbg
);

    state_t      state;
    state_t      state_next;
    alu_mode_t   alu_mode;
    logic        alu_en;
    logic [3:0]  dec_ctrl;
    logic        illegal_q;
    logic [31:0] count_q;

    mips_alu_decoder u_alu_dec (
        .mode     (alu_mode),
        .opcode   (opcode),
        .funct    (funct),
        .alu_ctrl (dec_ctrl)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE:   state_next = decode_target(opcode, ILLEGAL_TRAP);
            S_MEM_ADDR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_next = S_MEM_WB;
            S_MEM_WB:   state_next = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
            S_R_EXEC:   state_next = S_R_WB;
            S_R_WB:     state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JUMP:     state_next = S_FETCH;
            S_I_EXEC:   state_next = S_I_WB;
            S_I_WB:     state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            count_q   <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_FETCH && mem_ready)
                count_q <= count_q + 32'd1;
            if (state_next == S_TRAP)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_source  = PCSRC_ALU;
        alu_mode   = ALU_MODE_ADD;
        alu_en     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_en    = 1'b1;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_BRANCH;
                alu_en    = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_en    = 1'b1;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_mode  = ALU_MODE_FUNCT;
                alu_en    = 1'b1;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_mode  = ALU_MODE_SUB;
                alu_en    = 1'b1;
                pc_source = PCSRC_ALUOUT;
                pc_write  = (opcode == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_mode  = ALU_MODE_IMM;
                alu_en    = 1'b1;
            end
            S_I_WB: begin
                reg_write = 1'b1;
            end
            default: ;
        endcase
        // Reset abandons the instruction in flight: no write or request escapes.
        if (reset) begin
            pc_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign alu_ctrl    = alu_en ? dec_ctrl : 4'b0000;
    assign illegal     = illegal_q;
    assign instr_count = count_q;
    assign state_dbg   = state;

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multicycle control FSM for the MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for the supported subset.
- Drives every datapath mux select and write enable, including the ALU B-select that picks the immediate shifted left by 2 (branch target) and the PC-source select that picks the jump target.
- Holds off on a ready handshake with the unified instruction/data memory.

Parameters:
- ILLEGAL_TRAP, 1, 1 = unknown opcode enters TRAP state; 0 = unknown opcode is treated as NOP and returns to FETCH.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  load PC
- i_or_d  out  1  0 = memory address from PC, 1 = from ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left by 2
- alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], instr[25:0], 2'b00}
- illegal  out  1  sticky, set in TRAP
- instr_count  out  32  count of retired fetches
- state_dbg  out  4  current state encoding

Behaviour:
- Reset is synchronous and active-high. On reset: state = FETCH, instr_count = 0, illegal = 0. All enables (pc_write, mem_read, mem_write, ir_write, reg_write) are 0 during any cycle with reset high. Reset mid-instruction abandons it with no partial write.
- Outputs are combinational from state, plus mem_ready/zero/opcode where noted. Unlisted outputs are 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ADD, pc_source=00.
  - ir_write and pc_write = mem_ready.
  - mem_ready=1: instr_count += 1 (wraps at 2^32), go to DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (ALUOut = PC+4 + imm<<2). Next state by opcode:
  - 000000 → R_EXEC
  - 100011 / 101011 → MEM_ADDR
  - 000100 / 000101 → BRANCH
  - 000010 → JUMP
  - 001000 / 001100 / 001101 / 001010 → I_EXEC
  - other → TRAP (or FETCH if ILLEGAL_TRAP=0)
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Stay until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Stay until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT.
  - Other funct → ADD.
  - Then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01.
  - pc_write = zero for beq, ~zero for bne.
  - Then FETCH.
- JUMP: pc_source=10, pc_write=1, then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_ctrl ADD/AND/OR/SLT for addi/andi/ori/slti. Then I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
- TRAP: all enables 0, illegal=1. Held until reset.
- mem_read and mem_write are never asserted in the same cycle. Requests stay asserted and stable while mem_ready=0.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Latency with zero-wait memory (mem_ready held 1):
  - R-type / I-type / lw: 4 / 4 / 5 cycles.
  - sw / beq / bne / j: 4 / 3 / 3 / 3 cycles.
  - Each wait cycle adds 1.

Decomposition:
- Shared package mips_pkg holds:
  - opcode and funct constants
  - state enum (4-bit)
  - alu_ctrl codes
  - alu_src_b and pc_source encodings
- One sub-module, mips_alu_decoder: combinational {mode, opcode, funct} → alu_ctrl. Mode is add / sub / funct / imm.
- The FSM register, outputs and instr_count stay in mips_mc_control.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 → state_dbg=FETCH, pc_write=1 on the first post-reset cycle, instr_count=1 after that edge; all enables 0 while reset is high.
- add (opcode 000000, funct 100000), mem_ready=1 → states FETCH, DECODE, R_EXEC, R_WB; alu_ctrl=0010 in R_EXEC; reg_write=1 with reg_dst=1 only in R_WB; 4 cycles total.
- lw (100011) with mem_ready low 3 cycles in MEM_RD → mem_read=1 and i_or_d=1 held for 4 cycles; MEM_WB has mem_to_reg=1 and reg_write=1; 8 cycles total.
- beq (000100), zero=0 then a second beq with zero=1 → pc_write=0 in BRANCH, then 1 with pc_source=01; alu_src_b=11 in DECODE.
- j (000010) → pc_write=1 and pc_source=10 in JUMP; instr_count increments exactly once per instruction.
- Opcode 111111, ILLEGAL_TRAP=1 → TRAP, illegal=1, no enables for 10 cycles; reset asserted → illegal=0 and state FETCH.
